// File: rtl/sram_master.sv
// sram_master
// Initiator for an asynchronous SRAM-style parallel bus (active-low CE/OE/WE,
// shared bidirectional data). Each accepted request becomes one bus cycle made
// of a SETUP, a STROBE and an optional HOLD phase, with lengths set by
// parameters. The tristate pad buffers live outside this block: it only drives
// sram_dout / sram_data_oe and samples sram_din.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   req, req_we           request strobe (sampled only when idle), 1 = write
//   req_add, req_wdata    address and write data, latched with req
//   busy, done            transaction in progress / one-cycle completion pulse
//   rdata                 last read word, held until the next read completes
//   sram_ce_n/oe_n/we_n   bus strobes, active low
//   sram_add, sram_dout   bus address and outgoing data
//   sram_data_oe          pad output enable (1 = FPGA drives the data bus)
//   sram_din              incoming data from the pads
module sram_master #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADD_WIDTH     = 18,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  req_we,
    input  logic [ADD_WIDTH-1:0]  req_add,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [ADD_WIDTH-1:0]  sram_add,
    output logic [DATA_WIDTH-1:0] sram_dout,
    output logic                  sram_data_oe,
    input  logic [DATA_WIDTH-1:0] sram_din
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    // The phase counter is loaded with (length - 1) on entry and the phase
    // ends on the cycle the counter reads zero.
    localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD   = 8'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam bit         HAS_HOLD    = (HOLD_CYCLES > 0);

    state_t     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       wr_reg, wr_next;
    logic       accept, capture;
    logic       ce_n_next, oe_n_next, we_n_next, data_oe_next, busy_next, done_next;

    always_comb begin
        state_next = state_reg;
        cnt_next   = (cnt_reg == 8'd0) ? 8'd0 : cnt_reg - 8'd1;
        wr_next    = wr_reg;
        accept     = 1'b0;
        capture    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    wr_next    = req_we;
                    state_next = SETUP;
                    cnt_next   = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (cnt_reg == 8'd0) begin
                    state_next = STROBE;
                    cnt_next   = STROBE_LOAD;
                end
            end
            STROBE: begin
                if (cnt_reg == 8'd0) begin
                    // Read data is taken on the edge that releases OE.
                    capture = !wr_reg;
                    if (HAS_HOLD) begin
                        state_next = HOLD;
                        cnt_next   = HOLD_LOAD;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = 8'd0;
                    end
                end
            end
            HOLD: begin
                if (cnt_reg == 8'd0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase

        // Bus controls are decoded from the upcoming state and registered, so
        // the pins change cleanly on the same edge as the state register.
        ce_n_next    = (state_next == IDLE);
        oe_n_next    = !((state_next == STROBE) && !wr_next);
        we_n_next    = !((state_next == STROBE) && wr_next);
        data_oe_next = wr_next && (state_next != IDLE);
        busy_next    = (state_next != IDLE);
        done_next    = (state_reg != IDLE) && (state_next == IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= 8'd0;
            wr_reg       <= 1'b0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_data_oe <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            rdata        <= '0;
            sram_add     <= '0;
            sram_dout    <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            wr_reg       <= wr_next;
            sram_ce_n    <= ce_n_next;
            sram_oe_n    <= oe_n_next;
            sram_we_n    <= we_n_next;
            sram_data_oe <= data_oe_next;
            busy         <= busy_next;
            done         <= done_next;
            if (accept) begin
                sram_add  <= req_add;
                sram_dout <= req_wdata;
            end
            if (capture) begin
                rdata <= sram_din;
            end
        end
    end

endmodule

// File: tb/tb_sram_master.sv
// Testbench for sram_master. Two instances run side by side: index 0 with the
// default 1/2/1 phase lengths and index 1 with SETUP=3, STROBE=1, HOLD=0.
// Each instance sits on a behavioural SRAM. Expected bus waveforms come from
// the cycle-after-request timing rules; expected memory and read data come
// from a separate reference memory updated per transaction.
module tb_sram_master;
    localparam int DW = 16;
    localparam int AW = 18;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset     [2];
    logic          req       [2];
    logic          req_we    [2];
    logic [AW-1:0] req_add   [2];
    logic [DW-1:0] req_wdata [2];
    logic          busy      [2];
    logic          done      [2];
    logic [DW-1:0] rdata     [2];
    logic          ce_n      [2];
    logic          oe_n      [2];
    logic          we_n      [2];
    logic [AW-1:0] sadd      [2];
    logic [DW-1:0] dout      [2];
    logic          data_oe   [2];
    logic [DW-1:0] din       [2];

    int s_len [2] = '{1, 3};
    int t_len [2] = '{2, 1};
    int h_len [2] = '{1, 0};

    sram_master dut0 (
        .clock(clock), .reset(reset[0]), .req(req[0]), .req_we(req_we[0]),
        .req_add(req_add[0]), .req_wdata(req_wdata[0]), .busy(busy[0]),
        .done(done[0]), .rdata(rdata[0]), .sram_ce_n(ce_n[0]),
        .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]), .sram_add(sadd[0]),
        .sram_dout(dout[0]), .sram_data_oe(data_oe[0]), .sram_din(din[0])
    );

    sram_master #(.SETUP_CYCLES(3), .STROBE_CYCLES(1), .HOLD_CYCLES(0)) dut1 (
        .clock(clock), .reset(reset[1]), .req(req[1]), .req_we(req_we[1]),
        .req_add(req_add[1]), .req_wdata(req_wdata[1]), .busy(busy[1]),
        .done(done[1]), .rdata(rdata[1]), .sram_ce_n(ce_n[1]),
        .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]), .sram_add(sadd[1]),
        .sram_dout(dout[1]), .sram_data_oe(data_oe[1]), .sram_din(din[1])
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory contents: bus_mem is what the SRAM actually stored, ref_mem is
    // what the requests say it should hold. Key = {instance, address}.
    logic [DW-1:0] bus_mem [bit [AW:0]];
    logic [DW-1:0] ref_mem [bit [AW:0]];
    logic [DW-1:0] last_rd [2];
    bit            inv_en = 1'b0;

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hC3C3;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input int id, input logic [AW-1:0] a);
        bit [AW:0] key;
        key = {id[0], a};
        if (ref_mem.exists(key)) return ref_mem[key];
        return dflt(a);
    endfunction

    function automatic logic [DW-1:0] bus_rd(input int id, input logic [AW-1:0] a);
        bit [AW:0] key;
        key = {id[0], a};
        if (bus_mem.exists(key)) return bus_mem[key];
        return dflt(a);
    endfunction

    // Expected {ce_n, oe_n, we_n, data_oe, busy, done} in cycle k after the
    // accepting edge (k = 0 means idle, no transaction in flight).
    function automatic logic [5:0] exp_vec(input int id, input logic we, input int k);
        int n;
        bit act, stb;
        n   = s_len[id] + t_len[id] + h_len[id];
        act = (k >= 1) && (k <= n);
        stb = (k > s_len[id]) && (k <= s_len[id] + t_len[id]);
        return {~act, ~(stb && !we), ~(stb && we), we && act, act, (k == n + 1)};
    endfunction

    // Behavioural SRAM: stores on WE low, returns data on OE low, noise otherwise.
    // Also watches the strobe invariants every cycle.
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!ce_n[i] && !we_n[i] && data_oe[i]) bus_mem[{i[0], sadd[i]}] = dout[i];
            if (!ce_n[i] && !oe_n[i]) din[i] = bus_rd(i, sadd[i]);
            else din[i] = 16'($urandom);
            if (inv_en) begin
                chk("oe_we_overlap", 32'(!oe_n[i] && !we_n[i]), 32'd0);
                chk("drive_during_oe", 32'(data_oe[i] && !oe_n[i]), 32'd0);
            end
        end
    end

    function automatic logic [5:0] pins(input int id);
        return {ce_n[id], oe_n[id], we_n[id], data_oe[id], busy[id], done[id]};
    endfunction

    task automatic idle(input int id, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clock); #1;
            chk("idle_pins", 32'(pins(id)), 32'(exp_vec(id, 1'b0, 0)));
        end
    endtask

    // Runs one transaction; returns in the done cycle so a following call
    // presents its request during done (back-to-back acceptance).
    task automatic run_txn(input int id, input logic we, input logic [AW-1:0] add,
                           input logic [DW-1:0] wd, input bit poke);
        int n;
        n = s_len[id] + t_len[id] + h_len[id];
        $display("txn dut%0d %s add=%05h data=%04h poke=%0d", id, we ? "WR" : "RD", add, wd, poke);
        req[id] = 1'b1; req_we[id] = we; req_add[id] = add; req_wdata[id] = wd;
        @(posedge clock); #1;
        req[id] = 1'b0; req_we[id] = ~we;
        req_add[id] = AW'($urandom); req_wdata[id] = DW'($urandom);
        if (we) ref_mem[{id[0], add}] = wd;
        else last_rd[id] = ref_rd(id, add);
        for (int k = 1; k <= n + 1; k++) begin
            if (k > 1) begin
                @(posedge clock); #1;
            end
            if (poke) req[id] = (k == 2);
            chk("bus_pins", 32'(pins(id)), 32'(exp_vec(id, we, k)));
            if (k <= n) begin
                chk("sram_add", 32'(sadd[id]), 32'(add));
                if (we) chk("sram_dout", 32'(dout[id]), 32'(wd));
            end
        end
        chk("rdata", 32'(rdata[id]), 32'(last_rd[id]));
        if (we) chk("mem_write", 32'(bus_rd(id, add)), 32'(wd));
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b1; req[i] = 1'b0; req_we[i] = 1'b0;
            req_add[i] = '0; req_wdata[i] = '0; last_rd[i] = '0;
        end
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_pins", 32'(pins(i)), 32'(exp_vec(i, 1'b0, 0)));
            chk("reset_rdata", 32'(rdata[i]), 32'd0);
            chk("reset_add", 32'(sadd[i]), 32'd0);
            chk("reset_dout", 32'(dout[i]), 32'd0);
            reset[i] = 1'b0;
        end
        inv_en = 1'b1;

        bus_mem[{1'b0, 18'h00013}] = 16'hA5A5;
        ref_mem[{1'b0, 18'h00013}] = 16'hA5A5;

        // Directed cases on the default timing.
        run_txn(0, 1'b1, 18'h00012, 16'h5A5A, 1'b0); idle(0, 1);
        run_txn(0, 1'b0, 18'h00013, 16'h0000, 1'b0); idle(0, 2);
        run_txn(0, 1'b1, 18'h00014, 16'h7777, 1'b0); idle(0, 1);
        run_txn(0, 1'b1, 18'h00001, 16'h1234, 1'b0);
        run_txn(0, 1'b0, 18'h00001, 16'h0000, 1'b0); idle(0, 1);
        run_txn(0, 1'b1, 18'h00020, 16'hBEEF, 1'b1); idle(0, 2);

        // Directed cases on the 3/1/0 instance.
        run_txn(1, 1'b0, 18'h00013, 16'h0000, 1'b0); idle(1, 1);
        run_txn(1, 1'b1, 18'h00005, 16'hCAFE, 1'b0);
        run_txn(1, 1'b0, 18'h00005, 16'h0000, 1'b1); idle(1, 1);

        // Reset during the STROBE phase of a write.
        $display("txn dut0 WR add=3ffff data=dead reset-in-strobe");
        req[0] = 1'b1; req_we[0] = 1'b1; req_add[0] = 18'h3FFFF; req_wdata[0] = 16'hDEAD;
        @(posedge clock); #1;
        req[0] = 1'b0;
        @(posedge clock); #1;
        chk("pre_reset_pins", 32'(pins(0)), 32'(exp_vec(0, 1'b1, 2)));
        reset[0] = 1'b1;
        @(posedge clock); #1;
        reset[0] = 1'b0;
        chk("mid_reset_pins", 32'(pins(0)), 32'(exp_vec(0, 1'b0, 0)));
        chk("mid_reset_rdata", 32'(rdata[0]), 32'd0);
        last_rd[0] = '0;
        idle(0, 1);
        run_txn(0, 1'b0, 18'h00013, 16'h0000, 1'b0); idle(0, 1);

        // Randomized mix over a small address pool so reads hit earlier writes.
        for (int r = 0; r < 40; r++) begin
            int id;
            id = (r % 3 == 2) ? 1 : 0;
            run_txn(id, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom),
                    ($urandom_range(0, 4) == 0));
            idle(id, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_master.md
# sram_master

Initiator for the asynchronous SRAM-style parallel bus (active-low CE/OE/WE, shared bidirectional data). It turns single-word read/write requests from internal fabric logic into properly timed bus cycles, with setup, strobe and hold phases set by parameters. It sits beside the top-level SB_IO tristate instance. The block only drives `sram_dout` and `sram_data_oe` and samples `sram_din`; the pad buffers live in the top module.

## Interface
- DATA_WIDTH, 16, data bus width
- ADD_WIDTH, 18, address bus width
- SETUP_CYCLES, 1, CE low and address valid before strobe (1..255)
- STROBE_CYCLES, 2, OE or WE low time (1..255)
- HOLD_CYCLES, 1, CE low and address/data held after strobe release (0..255)
- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req  in  1  transaction request, sampled only in IDLE
- req_we  in  1  1 = write, 0 = read; latched with req
- req_add  in  ADD_WIDTH  target address; latched with req
- req_wdata  in  DATA_WIDTH  write data; latched with req
- busy  out  1  high while a transaction is in progress
- done  out  1  one-cycle pulse when a transaction completes
- rdata  out  DATA_WIDTH  last read word; holds until the next read completes
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  bus strobes, active low
- sram_add  out  ADD_WIDTH  bus address
- sram_dout  out  DATA_WIDTH  data to pad buffers
- sram_data_oe  out  1  pad output enable, 1 = FPGA drives the bus
- sram_din  in  DATA_WIDTH  data from pad buffers

## Operation
- States: IDLE, SETUP, STROBE, HOLD. An 8-bit phase counter is loaded on each state entry and counts down to the state exit.
- IDLE
  - ce_n = oe_n = we_n = 1, data_oe = 0, busy = 0.
  - req = 1 at an edge latches we/add/wdata and moves to SETUP.
- SETUP (SETUP_CYCLES cycles)
  - ce_n = 0, sram_add = latched address.
  - For a write, data_oe = 1 and sram_dout = latched wdata from the first SETUP cycle.
- STROBE (STROBE_CYCLES cycles)
  - Read: oe_n = 0. Write: we_n = 0.
  - A read captures sram_din into rdata on the edge that leaves STROBE.
- HOLD (HOLD_CYCLES cycles)
  - oe_n = we_n = 1. ce_n, address and (for a write) data_oe/dout are unchanged.
  - HOLD_CYCLES = 0 skips straight from STROBE to IDLE.
- Return to IDLE: done = 1 for exactly that first IDLE cycle, ce_n = 1, data_oe = 0.
- Invariants:
  - oe_n and we_n are never low together.
  - data_oe is never 1 while oe_n = 0.
  - data_oe is 0 for reads in every state.
- req while busy is ignored; there is no queue. A req held high during the done cycle is accepted on that edge. This guarantees at least one cycle with ce_n = 1 between transactions (bus turnaround).
- Strobes and data_oe come straight from registers, so outputs are glitch-free.
- Reset values: state = IDLE, all strobes 1, data_oe = 0, busy = 0, done = 0, rdata = 0, sram_add = 0, sram_dout = 0.
- Reset mid-transaction: on the next edge all strobes go high and data_oe = 0. No done pulse. rdata clears to 0.

## Timing
- Edge E0 accepts req. busy is high for exactly SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES cycles after E0. done rises in the following cycle.
- With defaults (1/2/1):
  - ce_n is low in cycles 1–4 after E0.
  - The strobe is low in cycles 2–3.
  - done is high in cycle 5.
  - Minimum request-to-request period is 5 cycles.
- Read data is sampled at the last strobe edge, i.e. at the end of STROBE_CYCLES cycles of OE low. rdata is valid from the first HOLD cycle and is guaranteed valid when done = 1.
- Write data is stable from the first SETUP cycle through the last HOLD cycle, so it covers the whole WE-low window plus HOLD_CYCLES.

## Test plan
- Write 0x5A5A to 0x00012 (defaults) -> behavioural SRAM model holds 0x5A5A at 0x00012. we_n low exactly 2 cycles, ce_n low 4 cycles, done pulse 1 cycle in cycle 5.
- Read 0x00013 preloaded with 0xA5A5 -> oe_n low 2 cycles, data_oe stays 0, rdata = 0xA5A5 at done. rdata unchanged after a later write.
- Back-to-back: req held high across write 0x0001/0x1234 then read 0x0001 -> ce_n high for exactly 1 cycle between cycles, rdata = 0x1234, the oe_n/we_n overlap checker never fires.
- HOLD_CYCLES = 0, SETUP_CYCLES = 3, STROBE_CYCLES = 1 -> busy 4 cycles, strobe low only in cycle 4, done in cycle 5.
- req pulsed while busy -> ignored; exactly one done and one bus cycle observed.
- reset asserted during STROBE of a write -> next edge: we_n = 1, ce_n = 1, data_oe = 0, busy = 0, no done, rdata = 0. A new req afterwards completes normally.
